// File: rtl/mux_2_1_rr_arb.sv
// Two-input round-robin stream arbiter with one registered output slot and source select s0.
// Optional per-input grant counters are built when MUX_ARB_CNT_EN is defined.
module mux_2_1_rr_arb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i0_valid,
    input  logic [WIDTH-1:0] i0_data,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [WIDTH-1:0] i1_data,
    output logic             i1_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             s0
`ifdef MUX_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    logic load;
    logic g0;
    logic g1;
    logic last;

    // last holds the index of the most recent winner; a tie goes to the other input
    always_comb begin
        load = ~y_valid | y_ready;
        g0   = i0_valid & (~i1_valid | last);
        g1   = i1_valid & (~i0_valid | ~last);
    end

    assign i0_ready = load & g0;
    assign i1_ready = load & g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            s0      <= 1'b0;
            last    <= 1'b1;
        end else if (load) begin
            if (g0 | g1) begin
                y_data  <= g1 ? i1_data : i0_data;
                y_valid <= 1'b1;
                s0      <= g1;
                last    <= g1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (i0_valid & i0_ready) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (i1_valid & i1_ready) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2_1_rr_arb.sv
// Bench for mux_2_1_rr_arb: directed scenarios followed by random traffic,
// all compared against a slot/priority reference model.
module tb_mux_2_1_rr_arb;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i0_valid = 1'b0;
    logic [WIDTH-1:0] i0_data = '0;
    logic             i0_ready;
    logic             i1_valid = 1'b0;
    logic [WIDTH-1:0] i1_data = '0;
    logic             i1_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready = 1'b0;
    logic             s0;
`ifdef MUX_ARB_CNT_EN
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    // reference model: output slot contents, which input wins the next tie, beat counts
    int m_yv, m_yd, m_s0, m_pref;
    int m_c0, m_c1;

    always #5 clk = ~clk;

    mux_2_1_rr_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
        .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .s0(s0)
`ifdef MUX_ARB_CNT_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_yv = 0; m_yd = 0; m_s0 = 0; m_pref = 0; m_c0 = 0; m_c1 = 0;
    endtask

    // Called at posedge+1: drive one cycle of inputs, check readies, clock, check outputs.
    task automatic cycle(input bit v0, input int d0, input bit v1, input int d1, input bit yr);
        int  winner;
        bit  slot_free;
        i0_valid = v0; i0_data = d0[WIDTH-1:0];
        i1_valid = v1; i1_data = d1[WIDTH-1:0];
        y_ready  = yr;
        #1;
        slot_free = (m_yv == 0) || yr;
        if (v0 && v1)  winner = m_pref;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
        else           winner = -1;
        check("i0_ready", i0_ready, slot_free && winner == 0);
        check("i1_ready", i1_ready, slot_free && winner == 1);
        @(posedge clk); #1;
        if (slot_free && winner >= 0) begin
            m_yv = 1;
            m_yd = (winner == 0) ? d0 % 256 : d1 % 256;
            m_s0 = winner;
            m_pref = 1 - winner;
            if (winner == 0) m_c0 = (m_c0 + 1) % (1 << CNT_W);
            else             m_c1 = (m_c1 + 1) % (1 << CNT_W);
        end else if (slot_free) begin
            m_yv = 0;
        end
        check("y_valid", y_valid, m_yv);
        check("y_data", y_data, m_yd);
        check("s0", s0, m_s0);
`ifdef MUX_ARB_CNT_EN
        check("gnt_cnt0", gnt_cnt0, m_c0);
        check("gnt_cnt1", gnt_cnt1, m_c1);
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_s0", s0, 0);
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();

        // contention from reset: A0,B0,A0,B0
        for (int k = 0; k < 4; k++) begin
            cycle(1, 'hA0, 1, 'hB0, 1);
            check("cont_data", y_data, (k % 2 == 0) ? 'hA0 : 'hB0);
            check("cont_s0", s0, k % 2);
        end

        // single source stream, one cycle latency
        cycle(1, 'h11, 0, 0, 1);
        check("single_0", y_data, 'h11);
        cycle(1, 'h22, 0, 0, 1);
        check("single_1", y_data, 'h22);
        cycle(1, 'h33, 0, 0, 1);
        check("single_2", y_data, 'h33);
        check("single_s0", s0, 0);

        // backpressure on a held 0x5A beat
        cycle(1, 'h5A, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 'h77, 1, 'h88, 0);
            check("bp_data", y_data, 'h5A);
            check("bp_s0", s0, 0);
        end
        cycle(1, 'h77, 1, 'h88, 1);
        check("bp_release_valid", y_valid, 1);
        check("bp_release_src", s0, 1);

        // idle cycles do not rotate priority
        cycle(0, 0, 1, 'h33, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("idle_empty", y_valid, 0);
        cycle(1, 'hC1, 1, 'hC2, 1);
        check("idle_i0_first", y_data, 'hC1);

        // asynchronous reset mid-transfer with a beat held in the slot
        cycle(0, 0, 1, 'h44, 0);
        check("pre_rst_valid", y_valid, 1);
        #3;
        apply_reset();
        cycle(1, 'h01, 1, 'h02, 1);
        check("post_rst_i0_first", s0, 0);

`ifdef MUX_ARB_CNT_EN
        apply_reset();
        for (int k = 0; k < 17; k++) cycle(0, 0, 1, k, 1);
        check("cnt1_wrap", gnt_cnt1, 1);
        check("cnt0_zero", gnt_cnt0, 0);
`endif

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
